// File: rtl/sap_display_pkg.sv
// Shared definitions for the SAP-U output display stage: FSM encoding,
// seven-segment patterns, scan digit positions and a BCD-to-segment helper.
package sap_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [1:0] DIG_ONES = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_HUND = 2'd2;
    localparam logic [1:0] DIG_SIGN = 2'd3;

    localparam int BCD_DIGITS = 3;

    function automatic logic [6:0] seg_of_bcd(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to seven-segment decoder with a blanking input.
module seven_seg_decoder
    import sap_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blanked digits drive all segments off.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = seg_of_bcd(digit);
        end
    end

endmodule

// File: rtl/sap_output_display.sv
// SAP-U output register: captures a bus byte, converts it to decimal with a
// sequential double-dabble and scans it onto a 4-digit seven-segment display.
module sap_output_display
    import sap_display_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int REFRESH_DIV = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              out_load,
    input  logic              signed_mode,
    output logic [DATA_W-1:0] value,
    output logic              busy,
    output logic [6:0]        seg,
    output logic [3:0]        an
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_e             state_r;
    state_e             state_s;
    logic [DATA_W-1:0]  value_r;
    logic               neg_r;
    logic [SR_W-1:0]    sr_r;
    logic [SR_W-1:0]    sr_step_s;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [DATA_W-1:0]  mag_s;
    logic               busy_r;

    logic [3:0]         disp_ones_r;
    logic [3:0]         disp_tens_r;
    logic [3:0]         disp_hund_r;
    logic               disp_neg_r;
    logic               hund_blank_s;
    logic               tens_blank_s;

    logic [CNT_W-1:0]   cnt_r;
    logic [1:0]         idx_r;
    logic [1:0]         idx_s;
    logic [3:0]         dec_digit_s;
    logic               dec_blank_s;
    logic [6:0]         dec_seg_s;
    logic [6:0]         seg_s;
    logic [3:0]         an_s;
    logic [6:0]         seg_r;
    logic [3:0]         an_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (out_load) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r == BIT_LAST) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Magnitude of the incoming byte; only negative in signed mode is negated.
    always_comb begin
        mag_s = bus_in;
        if (signed_mode && bus_in[DATA_W-1]) begin
            mag_s = ~bus_in + DATA_W'(1);
        end else begin
            mag_s = bus_in;
        end
    end

    // One double-dabble iteration: add 3 to BCD nibbles >= 5, then shift left.
    always_comb begin
        logic [SR_W-1:0] adj;
        adj = sr_r;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (adj[DATA_W + 4*i +: 4] >= 4'd5) begin
                adj[DATA_W + 4*i +: 4] = adj[DATA_W + 4*i +: 4] + 4'd3;
            end else begin
                adj[DATA_W + 4*i +: 4] = adj[DATA_W + 4*i +: 4];
            end
        end
        sr_step_s = {adj[SR_W-2:0], 1'b0};
    end

    // Capture, conversion datapath and display registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r     <= '0;
            neg_r       <= 1'b0;
            sr_r        <= '0;
            bit_cnt_r   <= '0;
            busy_r      <= 1'b0;
            disp_ones_r <= 4'd0;
            disp_tens_r <= 4'd0;
            disp_hund_r <= 4'd0;
            disp_neg_r  <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (out_load) begin
                        value_r   <= bus_in;
                        neg_r     <= signed_mode & bus_in[DATA_W-1];
                        sr_r      <= {{BCD_W{1'b0}}, mag_s};
                        bit_cnt_r <= '0;
                    end
                end
                ST_SHIFT: begin
                    sr_r      <= sr_step_s;
                    bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                end
                ST_COMMIT: begin
                    disp_ones_r <= sr_r[DATA_W     +: 4];
                    disp_tens_r <= sr_r[DATA_W + 4 +: 4];
                    disp_hund_r <= sr_r[DATA_W + 8 +: 4];
                    disp_neg_r  <= neg_r;
                end
                default: begin
                    sr_r <= sr_r;
                end
            endcase
        end
    end

    assign hund_blank_s = (disp_hund_r == 4'd0);
    assign tens_blank_s = hund_blank_s && (disp_tens_r == 4'd0);

    // Refresh counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= DIG_ONES;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            idx_r <= idx_s;
        end
    end

    // Outputs are built from the upcoming index so each digit is lit for
    // exactly REFRESH_DIV cycles, starting right at reset.
    always_comb begin
        idx_s       = idx_r;
        dec_digit_s = disp_ones_r;
        dec_blank_s = 1'b0;
        an_s        = 4'b0001;
        seg_s       = dec_seg_s;
        if (cnt_r == CNT_LAST) begin
            idx_s = idx_r + 2'd1;
        end else begin
            idx_s = idx_r;
        end
        case (idx_s)
            DIG_ONES: begin
                dec_digit_s = disp_ones_r;
                dec_blank_s = 1'b0;
                an_s        = 4'b0001;
            end
            DIG_TENS: begin
                dec_digit_s = disp_tens_r;
                dec_blank_s = tens_blank_s;
                an_s        = 4'b0010;
            end
            DIG_HUND: begin
                dec_digit_s = disp_hund_r;
                dec_blank_s = hund_blank_s;
                an_s        = 4'b0100;
            end
            DIG_SIGN: begin
                dec_digit_s = 4'd0;
                dec_blank_s = 1'b1;
                an_s        = 4'b1000;
            end
            default: begin
                dec_digit_s = disp_ones_r;
                dec_blank_s = 1'b0;
                an_s        = 4'b0001;
            end
        endcase
        if (idx_s == DIG_SIGN) begin
            seg_s = disp_neg_r ? SEG_MINUS : SEG_BLANK;
        end else begin
            seg_s = dec_seg_s;
        end
    end

    seven_seg_decoder u_dec (
        .digit (dec_digit_s),
        .blank (dec_blank_s),
        .seg   (dec_seg_s)
    );

    // Registered display drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= 4'b0001;
            seg_r <= SEG_0;
        end else begin
            an_r  <= an_s;
            seg_r <= seg_s;
        end
    end

    assign value = value_r;
    assign busy  = busy_r;
    assign seg   = seg_r;
    assign an    = an_r;

endmodule

// File: tb/tb_sap_output_display.sv
// Directed self-checking bench for sap_output_display: reset, conversion of
// signed/unsigned values, blanking, busy collision and reset mid-conversion.
module tb_sap_output_display;

    localparam int DIV = 16;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1101111;
    localparam logic [6:0] SM = 7'b1000000;
    localparam logic [6:0] SB = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus_in = 8'd0;
    logic       out_load = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] value;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] cap_seg [4];
    int         cap_cnt [4];
    int         cap_bad;

    always #5 clk = ~clk;

    sap_output_display #(.DATA_W(8), .REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_in      (bus_in),
        .out_load    (out_load),
        .signed_mode (signed_mode),
        .value       (value),
        .busy        (busy),
        .seg         (seg),
        .an          (an)
    );

    task automatic do_load(input logic [7:0] v, input logic sm);
        @(negedge clk);
        bus_in      = v;
        signed_mode = sm;
        out_load    = 1'b1;
        @(negedge clk);
        out_load    = 1'b0;
    endtask

    // Counts negedge samples with busy high; -1 on timeout.
    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) n = -1;
    endtask

    task automatic capture_frame();
        repeat (2) @(negedge clk);
        cap_bad = 0;
        for (int i = 0; i < 4; i++) begin
            cap_cnt[i] = 0;
            cap_seg[i] = 7'h7f;
        end
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            case (an)
                4'b0001: begin cap_seg[0] = seg; cap_cnt[0]++; end
                4'b0010: begin cap_seg[1] = seg; cap_cnt[1]++; end
                4'b0100: begin cap_seg[2] = seg; cap_cnt[2]++; end
                4'b1000: begin cap_seg[3] = seg; cap_cnt[3]++; end
                default: cap_bad++;
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (an !== 4'b0001) begin n_fail++; $display("FAIL reset_an: got %b expected 0001", an); end
        n_checks++; if (seg !== S0) begin n_fail++; $display("FAIL reset_seg: got %b expected %b", seg, S0); end
        n_checks++; if (value !== 8'd0) begin n_fail++; $display("FAIL reset_value: got %h expected 00", value); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++; if (an !== 4'b0001) begin n_fail++; $display("FAIL reset_an_hold: got %b expected 0001", an); end
        @(negedge clk);
        n_checks++; if (an !== 4'b0010) begin n_fail++; $display("FAIL reset_an_adv: got %b expected 0010", an); end
        n_checks++; if (seg !== SB) begin n_fail++; $display("FAIL reset_tens_blank: got %b expected %b", seg, SB); end
    endtask

    task automatic test_unsigned_255();
        int n;
        logic [6:0] exp_seg [4];
        exp_seg = '{S5, S5, S2, SB};
        do_load(8'd255, 1'b0);
        n_checks++; if (value !== 8'd255) begin n_fail++; $display("FAIL u255_value: got %0d expected 255", value); end
        wait_busy(n);
        n_checks++; if (n !== 9) begin n_fail++; $display("FAIL u255_busy_cycles: got %0d expected 9", n); end
        capture_frame();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_seg[i]) begin n_fail++; $display("FAIL u255_digit%0d: got %b expected %b", i, cap_seg[i], exp_seg[i]); end
            n_checks++; if (cap_cnt[i] !== DIV) begin n_fail++; $display("FAIL u255_dwell%0d: got %0d expected %0d", i, cap_cnt[i], DIV); end
        end
        n_checks++; if (cap_bad !== 0) begin n_fail++; $display("FAIL u255_an_onehot: got %0d bad samples expected 0", cap_bad); end
    endtask

    task automatic test_signed();
        int n;
        logic [6:0] exp_ff [4];
        logic [6:0] exp_80 [4];
        exp_ff = '{S1, SB, SB, SM};
        exp_80 = '{S8, S2, S1, SM};
        do_load(8'hFF, 1'b1);
        wait_busy(n);
        n_checks++; if (n !== 9) begin n_fail++; $display("FAIL sFF_busy_cycles: got %0d expected 9", n); end
        capture_frame();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_ff[i]) begin n_fail++; $display("FAIL sFF_digit%0d: got %b expected %b", i, cap_seg[i], exp_ff[i]); end
        end
        do_load(8'h80, 1'b1);
        n_checks++; if (value !== 8'h80) begin n_fail++; $display("FAIL s80_value: got %h expected 80", value); end
        wait_busy(n);
        capture_frame();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_80[i]) begin n_fail++; $display("FAIL s80_digit%0d: got %b expected %b", i, cap_seg[i], exp_80[i]); end
        end
    endtask

    task automatic test_blanking();
        int n;
        logic [6:0] exp_0 [4];
        logic [6:0] exp_105 [4];
        exp_0   = '{S0, SB, SB, SB};
        exp_105 = '{S5, S0, S1, SB};
        do_load(8'd0, 1'b0);
        wait_busy(n);
        capture_frame();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_0[i]) begin n_fail++; $display("FAIL zero_digit%0d: got %b expected %b", i, cap_seg[i], exp_0[i]); end
        end
        do_load(8'd105, 1'b0);
        wait_busy(n);
        capture_frame();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_105[i]) begin n_fail++; $display("FAIL d105_digit%0d: got %b expected %b", i, cap_seg[i], exp_105[i]); end
        end
    endtask

    task automatic test_busy_collision();
        int n;
        logic [6:0] exp_7 [4];
        logic [6:0] exp_42 [4];
        exp_7  = '{S7, SB, SB, SB};
        exp_42 = '{S2, S4, SB, SB};
        do_load(8'd7, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL coll_busy_third: got %b expected 1", busy); end
        bus_in   = 8'd42;
        out_load = 1'b1;
        @(negedge clk);
        out_load = 1'b0;
        n_checks++; if (value !== 8'd7) begin n_fail++; $display("FAIL coll_value: got %0d expected 7", value); end
        wait_busy(n);
        n_checks++; if (n < 0) begin n_fail++; $display("FAIL coll_busy_timeout: got %0d expected >=0", n); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL coll_not_queued: got busy %b expected 0", busy); end
        capture_frame();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_7[i]) begin n_fail++; $display("FAIL coll7_digit%0d: got %b expected %b", i, cap_seg[i], exp_7[i]); end
        end
        do_load(8'd42, 1'b0);
        wait_busy(n);
        capture_frame();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_42[i]) begin n_fail++; $display("FAIL coll42_digit%0d: got %b expected %b", i, cap_seg[i], exp_42[i]); end
        end
    endtask

    task automatic test_reset_mid_shift();
        int n;
        logic [6:0] exp_rst [4];
        logic [6:0] exp_9 [4];
        exp_rst = '{S0, SB, SB, SB};
        exp_9   = '{S9, SB, SB, SB};
        do_load(8'd200, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (value !== 8'd0) begin n_fail++; $display("FAIL midrst_value: got %0d expected 0", value); end
        n_checks++; if (an !== 4'b0001) begin n_fail++; $display("FAIL midrst_an: got %b expected 0001", an); end
        n_checks++; if (seg !== S0) begin n_fail++; $display("FAIL midrst_seg: got %b expected %b", seg, S0); end
        capture_frame();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_rst[i]) begin n_fail++; $display("FAIL midrst_digit%0d: got %b expected %b", i, cap_seg[i], exp_rst[i]); end
        end
        do_load(8'd9, 1'b0);
        wait_busy(n);
        n_checks++; if (n !== 9) begin n_fail++; $display("FAIL load9_busy_cycles: got %0d expected 9", n); end
        capture_frame();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_9[i]) begin n_fail++; $display("FAIL load9_digit%0d: got %b expected %b", i, cap_seg[i], exp_9[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_255();
        test_signed();
        test_blanking();
        test_busy_collision();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
